interp_block_sequencer: RTL
===========================

// Module: interp_block_sequencer
// PURPOSE
//  Sequences one 8x8 interpolation block through the datapath:
//   - loads ROWS_IN reference rows into the input row shift register;
//   - issues WORDS_OUT filter operations;
//   - pushes each filter result into the output filler;
//   - hands the completed 2560-bit block downstream with a valid/ready handshake.
//  Sits between the row fetch unit and the input shift reg / filter / output filler.
// PARAMETERS
//  ROWS_IN    15  rows per block: 8 output rows + 7 filter taps
//  WORDS_OUT  40  64-bit result words per block: 8 rows x 5 subpel positions
//  PIPE_LAT   2   cycles from filt_en to result valid at output filler input; legal range 1..8
// PORTS
//  clock      in   1  single clock, all state on posedge
//  reset      in   1  synchronous, active-high
//  start      in   1  begin a block; sampled only in IDLE or on the cycle DONE hands off
//  row_valid  in   1  upstream row present on datapath input bus
//  row_ready  out  1  sequencer accepts a row this cycle
//  in_load_L  out  1  active-low load strobe to input row shift register
//  filt_en    out  1  issue one filter op
//  filt_idx   out  8  index 0..WORDS_OUT-1 of the op issued
//  out_load_L out  1  active-low load strobe to output filler
//  out_sel    out  8  output word index 0..WORDS_OUT-1 being written
//  blk_valid  out  1  completed block present on output filler bus
//  blk_ready  in   1  downstream accepts block
//  busy       out  1  high in any state except IDLE
// BEHAVIOUR
//  States and transitions:
//   IDLE --start--> FILL
//   FILL --ROWS_IN rows accepted--> ISSUE
//   ISSUE --WORDS_OUT ops issued--> FLUSH
//   FLUSH --WORDS_OUT results written--> DONE
//   DONE --blk_ready--> IDLE, or FILL if start is also high in that cycle.
//  Reset: state=IDLE, all counters 0.
//   - in_load_L=1, out_load_L=1; row_ready, filt_en, blk_valid, busy = 0; filt_idx, out_sel = 0.
//   - Reset mid-block aborts immediately, with no further strobes.
//  FILL:
//   - row_ready=1; in_load_L = ~(row_valid & row_ready), combinational.
//   - row_cnt increments per accepted row; leaves FILL on the accept where row_cnt==ROWS_IN-1.
//   - row_valid low stalls, with no timeout.
//  ISSUE:
//   - filt_en=1 every cycle, with no stalls; filt_idx = issue count.
//   - Exactly WORDS_OUT consecutive cycles.
//  Result pipe:
//   - filt_en delayed PIPE_LAT cycles through a shift register -> out_load_L (inverted).
//   - out_sel = write count, incrementing after each write.
//   - The pipe runs in every state and is cleared by reset.
//  FLUSH: waits until write count == WORDS_OUT. First write is PIPE_LAT cycles after the first filt_en.
//  DONE:
//   - blk_valid=1, held stable until blk_ready.
//   - Block handed off in the cycle blk_valid & blk_ready.
//  Rules:
//   - start is ignored in FILL, ISSUE and FLUSH; no queuing.
//   - in_load_L and out_load_L are never both low in the same cycle.
//   - All outputs are registered except in_load_L and row_ready.
//   - Datapath registers sample on negedge, so strobes are settled by mid-cycle.
//  Latency:
//   - start -> first row_ready: 1 cycle.
//   - Last row accepted -> first filt_en: 1 cycle.
//   - Last filt_en -> blk_valid: PIPE_LAT+1 cycles.
//  Counters are 8 bits with no wrap; the FSM guarantees max index = WORDS_OUT-1.
// STRUCTURE
//  Shared package interp_pkg:
//   - state encoding localparams S_IDLE, S_FILL, S_ISSUE, S_FLUSH, S_DONE;
//   - ROWS_IN, WORDS_OUT and PIPE_LAT defaults.
//  One sub-module: interp_delay_line (PIPE_LAT-deep 1-bit shift register, sync reset) for the result pipe.
//  Everything else is flat: FSM plus three counters.
// TESTING
//  1. Reset, start=1, row_valid=1 continuously:
//     - 15 in_load_L lows on cycles 1..15;
//     - filt_en on cycles 16..55;
//     - out_load_L on cycles 18..57, out_sel 0..39;
//     - blk_valid on cycle 58.
//  2. row_valid toggles 1/0 during FILL: exactly 15 loads over 29 cycles, no filt_en before the 15th load.
//  3. blk_ready held low 10 cycles in DONE:
//     - blk_valid stays 1, no strobes;
//     - then blk_ready=1 with start=1 -> row_ready=1 on the next cycle (back-to-back block).
//  4. reset asserted on the 20th cycle of ISSUE:
//     - the next cycle shows IDLE, busy=0, out_load_L=1;
//     - no residual out_load_L from the pipe.
//  5. start pulsed during FILL and ISSUE: ignored; exactly one block, blk_valid once.
//  6. Assertions throughout:
//     - never in_load_L=0 and out_load_L=0 together;
//     - out_sel < 40 on every write;
//     - filt_en count == out_load_L count per block.

Source files
------------

// File: rtl/interp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_pkg
// Purpose  : Shared defaults and state encoding for the interpolation block
//            sequencer and its result pipe.
// Contents : ROWS_IN_DEF, WORDS_OUT_DEF, PIPE_LAT_DEF, CNT_W, state_e
// Revision : 1.0 - initial release
// ============================================================================
package interp_pkg;

   localparam int ROWS_IN_DEF   = 15;  // 8 output rows + 7 filter taps
   localparam int WORDS_OUT_DEF = 40;  // 8 rows x 5 subpel positions
   localparam int PIPE_LAT_DEF  = 2;   // filt_en -> result at output filler
   localparam int CNT_W         = 8;   // width of every sequencing counter

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_ISSUE = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage : interp_pkg
`default_nettype wire

// File: rtl/interp_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_delay_line
// Purpose  : DEPTH-stage 1-bit shift register with synchronous reset; models
//            the filter pipeline latency from op issue to result arrival.
// Ports    : clk_i  - clock
//            rst_i  - synchronous active-high reset, clears every stage
//            d_i    - bit entering the pipe
//            q_o    - bit leaving the pipe DEPTH cycles later
// Revision : 1.0 - initial release
// ============================================================================
module interp_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sr_q;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk_i) begin
            if (rst_i) sr_q <= 1'b0;
            else       sr_q <= d_i;
         end
      end else begin : g_chain
         always_ff @(posedge clk_i) begin
            if (rst_i) sr_q <= '0;
            else       sr_q <= {sr_q[DEPTH-2:0], d_i};
         end
      end
   endgenerate

   assign q_o = sr_q[DEPTH-1];

endmodule : interp_delay_line
`default_nettype wire

// File: rtl/interp_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_block_sequencer
// Purpose  : Sequences one 8x8 interpolation block: loads ROWS_IN reference
//            rows, issues WORDS_OUT filter ops, writes each result into the
//            output filler and hands the finished block downstream.
// Ports    : clock_i       - clock, all state on posedge
//            reset_i       - synchronous active-high reset
//            start_i       - begin a block (IDLE, or DONE hand-off cycle)
//            row_valid_i   - upstream row present
//            row_ready_o   - row accepted this cycle (combinational)
//            in_load_L_o   - active-low input shift register load (comb.)
//            filt_en_o     - issue one filter op
//            filt_idx_o    - index of the op issued
//            out_load_L_o  - active-low output filler load
//            out_sel_o     - output word index being written
//            blk_valid_o   - completed block available
//            blk_ready_i   - downstream accepts block
//            busy_o        - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module interp_block_sequencer
   import interp_pkg::*;
#(
   parameter int ROWS_IN   = ROWS_IN_DEF,
   parameter int WORDS_OUT = WORDS_OUT_DEF,
   parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             row_valid_i,
   output logic             row_ready_o,
   output logic             in_load_L_o,
   output logic             filt_en_o,
   output logic [CNT_W-1:0] filt_idx_o,
   output logic             out_load_L_o,
   output logic [CNT_W-1:0] out_sel_o,
   output logic             blk_valid_o,
   input  logic             blk_ready_i,
   output logic             busy_o
);

   localparam logic [CNT_W-1:0] c_ROW_LAST  = CNT_W'(ROWS_IN - 1);
   localparam logic [CNT_W-1:0] c_WORD_LAST = CNT_W'(WORDS_OUT - 1);

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] row_cnt_q,   row_cnt_d;
   logic [CNT_W-1:0] filt_idx_q,  filt_idx_d;
   logic [CNT_W-1:0] out_sel_q,   out_sel_d;
   logic             filt_en_q,   filt_en_d;
   logic             blk_valid_q, blk_valid_d;
   logic             busy_q,      busy_d;

   logic w_row_acc;
   logic w_wr;

   // Row handshake is combinational so a row is taken the same cycle it is
   // offered; reset masks it so an aborted block emits no further load.
   assign row_ready_o = (state_q == S_FILL) & ~reset_i;
   assign w_row_acc   = row_valid_i & row_ready_o;
   assign in_load_L_o = ~w_row_acc;

   // Result pipe: a result reaches the output filler PIPE_LAT cycles after
   // its filter op was issued.
   interp_delay_line #(
      .DEPTH (PIPE_LAT)
   ) u_result_pipe (
      .clk_i (clock_i),
      .rst_i (reset_i),
      .d_i   (filt_en_q),
      .q_o   (w_wr)
   );

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      filt_idx_d  = filt_idx_q;
      out_sel_d   = out_sel_q;
      filt_en_d   = 1'b0;
      blk_valid_d = blk_valid_q;

      // Write counter follows the pipe in every state; it returns to zero
      // after the last word so the index never leaves 0..WORDS_OUT-1.
      if (w_wr) begin
         out_sel_d = (out_sel_q == c_WORD_LAST) ? '0 : out_sel_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FILL;
         end
         S_FILL: begin
            if (w_row_acc) begin
               if (row_cnt_q == c_ROW_LAST) begin
                  row_cnt_d = '0;
                  filt_en_d = 1'b1;   // first op lands the cycle after the last row
                  state_d   = S_ISSUE;
               end else begin
                  row_cnt_d = row_cnt_q + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (filt_idx_q == c_WORD_LAST) begin
               filt_idx_d = '0;
               state_d    = S_FLUSH;
            end else begin
               filt_idx_d = filt_idx_q + 1'b1;
               filt_en_d  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (w_wr && (out_sel_q == c_WORD_LAST)) begin
               blk_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (blk_ready_i) begin
               blk_valid_d = 1'b0;
               state_d     = start_i ? S_FILL : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         row_cnt_q   <= '0;
         filt_idx_q  <= '0;
         out_sel_q   <= '0;
         filt_en_q   <= 1'b0;
         blk_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         filt_idx_q  <= filt_idx_d;
         out_sel_q   <= out_sel_d;
         filt_en_q   <= filt_en_d;
         blk_valid_q <= blk_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign filt_en_o    = filt_en_q;
   assign filt_idx_o   = filt_idx_q;
   assign out_load_L_o = ~w_wr;
   assign out_sel_o    = out_sel_q;
   assign blk_valid_o  = blk_valid_q;
   assign busy_o       = busy_q;

endmodule : interp_block_sequencer
`default_nettype wire
